// File: rtl/msp_pkg.sv
// Shared definitions for the double-operand fetch path: sequencer states,
// addressing modes, special register indices and small operand helpers.
package msp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SRC_EXT,
    SRC_MEM,
    DST_EXT,
    DST_MEM,
    DONE
  } opseq_state_t;

  localparam logic [1:0] AM_REG = 2'b00;
  localparam logic [1:0] AM_IDX = 2'b01;
  localparam logic [1:0] AM_IND = 2'b10;
  localparam logic [1:0] AM_INC = 2'b11;

  localparam logic [3:0] R_PC = 4'd0;
  localparam logic [3:0] R_SP = 4'd1;
  localparam logic [3:0] R_SR = 4'd2;
  localparam logic [3:0] R_CG = 4'd3;

  localparam logic [3:0] OP_MOV = 4'h4;

  // need = {src_ext, src_mem, dst_ext, dst_mem}; returns the first required
  // state strictly after cur, falling through to DONE.
  function automatic opseq_state_t next_state(opseq_state_t cur, logic [3:0] need);
    opseq_state_t nxt;
    nxt = DONE;
    if (need[0] && (cur == IDLE || cur == SRC_EXT || cur == SRC_MEM || cur == DST_EXT))
      nxt = DST_MEM;
    if (need[1] && (cur == IDLE || cur == SRC_EXT || cur == SRC_MEM))
      nxt = DST_EXT;
    if (need[2] && (cur == IDLE || cur == SRC_EXT))
      nxt = SRC_MEM;
    if (need[3] && cur == IDLE)
      nxt = SRC_EXT;
    return nxt;
  endfunction

  // Word mode passes the word through; byte mode picks the addressed byte
  // and zero-extends it. Register operands always pass odd=0.
  function automatic logic [15:0] byte_sel(logic [15:0] w, logic bw, logic odd);
    if (!bw)
      return w;
    return odd ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
  endfunction

endpackage

// File: rtl/operand_sequencer_const_gen.sv
// Constant generator: R3 in any source mode and R2 in the two indirect
// modes yield fixed values without touching memory.
module const_gen
  import msp_pkg::*;
(
  input  logic [3:0]  reg_idx,
  input  logic [1:0]  as,
  output logic        hit,
  output logic [15:0] value
);

  // Decode the register/mode pair into a constant
  always_comb begin
    hit   = 1'b0;
    value = 16'h0000;
    if (reg_idx == R_CG) begin
      hit = 1'b1;
      case (as)
        AM_REG:  value = 16'h0000;
        AM_IDX:  value = 16'h0001;
        AM_IND:  value = 16'h0002;
        default: value = 16'hFFFF;
      endcase
    end else if (reg_idx == R_SR && (as == AM_IND || as == AM_INC)) begin
      hit   = 1'b1;
      value = (as == AM_IND) ? 16'h0004 : 16'h0008;
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Operand fetch sequencer for double-operand instructions. Walks the
// extension-word / memory-read states required by As and Ad, drives the
// register bank ports (PC advance, autoincrement) and presents src_op,
// dst_op and dst_ea with a one-cycle done pulse.
// Build option: OPSEQ_CONST_GEN_EN enables the R2/R3 constant generator.
module operand_sequencer
  import msp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] instruction,
  output logic        busy,
  output logic        done,
  output logic [3:0]  reg_rd_addr,
  input  logic [15:0] reg_rd_data,
  output logic        reg_wr_en,
  output logic [3:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] src_op,
  output logic [15:0] dst_op,
  output logic [15:0] dst_ea,
  output logic        dst_is_mem
);

  opseq_state_t state;

  logic [3:0]  opcode_reg, rs_reg, rd_reg, need_reg;
  logic [1:0]  as_reg;
  logic        ad_reg, bw_reg, src_imm_reg;
  logic [15:0] src_op_reg, src_ea_reg, dst_x_reg, xaddr_reg, dst_ea_reg, dst_op_reg;

  logic        cg_hit;
  logic [15:0] cg_value;
  logic [3:0]  need_in;
  logic        src_imm_in;
  logic [15:0] inc_val, src_idx_base, dst_base, dst_ea_calc, dst_op_cmb, dst_ea_cmb;

`ifdef OPSEQ_CONST_GEN_EN
  const_gen u_const_gen (
    .reg_idx (instruction[11:8]),
    .as      (instruction[5:4]),
    .hit     (cg_hit),
    .value   (cg_value)
  );
`else
  assign cg_hit   = 1'b0;
  assign cg_value = 16'h0000;
`endif

  // Work out which fetch states the incoming instruction needs
  always_comb begin
    src_imm_in = (instruction[5:4] == AM_INC) && (instruction[11:8] == R_PC) && !cg_hit;
    need_in[3] = ((instruction[5:4] == AM_IDX) && !cg_hit) || src_imm_in;
    need_in[2] = (instruction[5:4] != AM_REG) && !src_imm_in && !cg_hit;
    need_in[1] = instruction[7];
    need_in[0] = instruction[7] && (instruction[15:12] != OP_MOV);
  end

  // Address arithmetic: autoincrement step and indexed/absolute/symbolic bases.
  // Symbolic destinations use the captured address of X, since PC has moved on.
  always_comb begin
    inc_val      = (bw_reg && rs_reg != R_PC && rs_reg != R_SP) ? 16'd1 : 16'd2;
    src_idx_base = (rs_reg == R_SR) ? 16'h0000 :
                   (rs_reg == R_PC) ? reg_rd_data : src_ea_reg;
    dst_base     = (rd_reg == R_SR) ? 16'h0000 :
                   (rd_reg == R_PC) ? xaddr_reg : reg_rd_data;
    dst_ea_calc  = dst_base + dst_x_reg;
  end

  // Destination results are read from the bank during DONE and held afterwards
  always_comb begin
    dst_op_cmb = dst_op_reg;
    dst_ea_cmb = dst_ea_reg;
    if (state == DONE) begin
      if (!ad_reg) begin
        dst_ea_cmb = 16'h0000;
        dst_op_cmb = byte_sel(reg_rd_data, bw_reg, 1'b0);
      end else if (opcode_reg == OP_MOV) begin
        dst_ea_cmb = dst_ea_calc;
      end
      if (opcode_reg == OP_MOV)
        dst_op_cmb = 16'h0000;
    end
  end

  // Port drive decoded from the state register
  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    mem_req     = (state == SRC_EXT) || (state == SRC_MEM) ||
                  (state == DST_EXT) || (state == DST_MEM);
    reg_rd_addr = 4'd0;
    mem_addr    = 16'h0000;
    reg_wr_en   = 1'b0;
    reg_wr_addr = 4'd0;
    reg_wr_data = 16'h0000;
    case (state)
      IDLE: begin
        if (start)
          reg_rd_addr = instruction[11:8];
      end
      SRC_EXT, DST_EXT: begin
        reg_rd_addr = R_PC;
        mem_addr    = reg_rd_data;
        if (mem_ack) begin
          reg_wr_en   = 1'b1;
          reg_wr_addr = R_PC;
          reg_wr_data = reg_rd_data + 16'd2;
        end
      end
      SRC_MEM: begin
        mem_addr = src_ea_reg;
        if (mem_ack && as_reg == AM_INC) begin
          reg_wr_en   = 1'b1;
          reg_wr_addr = rs_reg;
          reg_wr_data = src_ea_reg + inc_val;
        end
      end
      DST_MEM: begin
        reg_rd_addr = rd_reg;
        mem_addr    = dst_ea_calc;
      end
      DONE: reg_rd_addr = rd_reg;
      default: ;
    endcase
  end

  assign src_op     = src_op_reg;
  assign dst_op     = dst_op_cmb;
  assign dst_ea     = dst_ea_cmb;
  assign dst_is_mem = ad_reg;

  // Sequencer state and captured operands
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      opcode_reg  <= 4'd0;
      rs_reg      <= 4'd0;
      rd_reg      <= 4'd0;
      need_reg    <= 4'd0;
      as_reg      <= 2'd0;
      ad_reg      <= 1'b0;
      bw_reg      <= 1'b0;
      src_imm_reg <= 1'b0;
      src_op_reg  <= 16'h0000;
      src_ea_reg  <= 16'h0000;
      dst_x_reg   <= 16'h0000;
      xaddr_reg   <= 16'h0000;
      dst_ea_reg  <= 16'h0000;
      dst_op_reg  <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            opcode_reg  <= instruction[15:12];
            rs_reg      <= instruction[11:8];
            ad_reg      <= instruction[7];
            bw_reg      <= instruction[6];
            as_reg      <= instruction[5:4];
            rd_reg      <= instruction[3:0];
            need_reg    <= need_in;
            src_imm_reg <= src_imm_in;
            src_ea_reg  <= reg_rd_data;
            dst_x_reg   <= 16'h0000;
            if (cg_hit)
              src_op_reg <= byte_sel(cg_value, instruction[6], 1'b0);
            else if (instruction[5:4] == AM_REG)
              src_op_reg <= byte_sel(reg_rd_data, instruction[6], 1'b0);
            state <= next_state(IDLE, need_in);
          end
        end
        SRC_EXT: begin
          if (mem_ack) begin
            if (src_imm_reg)
              src_op_reg <= byte_sel(mem_rdata, bw_reg, 1'b0);
            else
              src_ea_reg <= src_idx_base + mem_rdata;
            state <= next_state(SRC_EXT, need_reg);
          end
        end
        SRC_MEM: begin
          if (mem_ack) begin
            src_op_reg <= byte_sel(mem_rdata, bw_reg, src_ea_reg[0]);
            state      <= next_state(SRC_MEM, need_reg);
          end
        end
        DST_EXT: begin
          if (mem_ack) begin
            dst_x_reg <= mem_rdata;
            xaddr_reg <= reg_rd_data;
            state     <= next_state(DST_EXT, need_reg);
          end
        end
        DST_MEM: begin
          if (mem_ack) begin
            dst_ea_reg <= dst_ea_calc;
            dst_op_reg <= byte_sel(mem_rdata, bw_reg, dst_ea_calc[0]);
            state      <= DONE;
          end
        end
        DONE: begin
          dst_op_reg <= dst_op_cmb;
          dst_ea_reg <= dst_ea_cmb;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
